// File: rtl/mp_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter (mp_arbiter)
// and its optional statistics block.
package mp_arb_pkg;

    // One-hot arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_OWN0 = 3'b010,
        ST_OWN1 = 3'b100
    } state_e;

    localparam logic PORT_I = 1'b0;  // instruction cache
    localparam logic PORT_D = 1'b1;  // data cache

    localparam int STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mp_arb_stats.sv
// Saturating grant/wait counters for mp_arbiter; only instantiated when
// MP_ARB_STATS_EN is defined.
module mp_arb_stats
    import mp_arb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              grant_0,
    input  logic              grant_1,
    input  logic              wait_0,
    input  logic              wait_1,
    output logic [STAT_W-1:0] grant_cnt_0,
    output logic [STAT_W-1:0] grant_cnt_1,
    output logic [STAT_W-1:0] wait_cnt_0,
    output logic [STAT_W-1:0] wait_cnt_1
);

    logic [STAT_W-1:0] grant_cnt_0_q, grant_cnt_0_d;
    logic [STAT_W-1:0] grant_cnt_1_q, grant_cnt_1_d;
    logic [STAT_W-1:0] wait_cnt_0_q,  wait_cnt_0_d;
    logic [STAT_W-1:0] wait_cnt_1_q,  wait_cnt_1_d;

    always_comb begin
        grant_cnt_0_d = grant_0 ? sat_inc(grant_cnt_0_q) : grant_cnt_0_q;
        grant_cnt_1_d = grant_1 ? sat_inc(grant_cnt_1_q) : grant_cnt_1_q;
        wait_cnt_0_d  = wait_0  ? sat_inc(wait_cnt_0_q)  : wait_cnt_0_q;
        wait_cnt_1_d  = wait_1  ? sat_inc(wait_cnt_1_q)  : wait_cnt_1_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_cnt_0_q <= '0;
            grant_cnt_1_q <= '0;
            wait_cnt_0_q  <= '0;
            wait_cnt_1_q  <= '0;
        end else begin
            grant_cnt_0_q <= grant_cnt_0_d;
            grant_cnt_1_q <= grant_cnt_1_d;
            wait_cnt_0_q  <= wait_cnt_0_d;
            wait_cnt_1_q  <= wait_cnt_1_d;
        end
    end

    assign grant_cnt_0 = grant_cnt_0_q;
    assign grant_cnt_1 = grant_cnt_1_q;
    assign wait_cnt_0  = wait_cnt_0_q;
    assign wait_cnt_1  = wait_cnt_1_q;

endmodule

// File: rtl/mp_arbiter.sv
// Two-port (I-cache / D-cache) arbiter for the single main-memory port; holds the
// grant for a whole block burst. Optional stats outputs under MP_ARB_STATS_EN.
module mp_arbiter
    import mp_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_WORDS = 2
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef MP_ARB_STATS_EN
    output logic [STAT_W-1:0] grant_cnt_0,
    output logic [STAT_W-1:0] grant_cnt_1,
    output logic [STAT_W-1:0] wait_cnt_0,
    output logic [STAT_W-1:0] wait_cnt_1,
`endif
    input  logic              mem_valid_0,
    input  logic              mem_instr_0,
    input  logic [ADDR_W-1:0] mem_addr_0,
    input  logic [DATA_W-1:0] mem_wdata_0,
    input  logic [3:0]        mem_wstrb_0,
    output logic              mem_ready_0,
    output logic [DATA_W-1:0] mem_rdata_0,
    input  logic              mem_valid_1,
    input  logic              mem_instr_1,
    input  logic [ADDR_W-1:0] mem_addr_1,
    input  logic [DATA_W-1:0] mem_wdata_1,
    input  logic [3:0]        mem_wstrb_1,
    output logic              mem_ready_1,
    output logic [DATA_W-1:0] mem_rdata_1,
    output logic              mem_valid_MP,
    output logic              mem_instr_MP,
    output logic [ADDR_W-1:0] mem_addr_MP,
    output logic [DATA_W-1:0] mem_wdata_MP,
    output logic [3:0]        mem_wstrb_MP,
    input  logic              mem_ready_MP,
    input  logic [DATA_W-1:0] mem_rdata_MP
);

    localparam int CNT_W = $clog2(BURST_WORDS + 1);

    state_e           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             owner_valid;
    logic [CNT_W-1:0] beat_inc;
    logic             burst_done;

    assign owner_valid = (state_q == ST_OWN1) ? mem_valid_1 : mem_valid_0;
    assign beat_inc    = beat_cnt_q + CNT_W'(1);
    assign burst_done  = mem_ready_MP && (beat_inc == CNT_W'(BURST_WORDS));

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_owner_q <= PORT_D;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // NOTE: hold-value defaults first keep this block free of inferred latches.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // On a tie the port that did not own last time wins.
                if (mem_valid_0 && (!mem_valid_1 || last_owner_q == PORT_D)) begin
                    state_d      = ST_OWN0;
                    last_owner_d = PORT_I;
                    beat_cnt_d   = '0;
                end else if (mem_valid_1) begin
                    state_d      = ST_OWN1;
                    last_owner_d = PORT_D;
                    beat_cnt_d   = '0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (mem_ready_MP) begin
                    if (burst_done) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end else if (!owner_valid) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Forwarding mux: everything toward memory and both readies are quiet in IDLE.
    always_comb begin
        mem_valid_MP = 1'b0;
        mem_instr_MP = 1'b0;
        mem_addr_MP  = '0;
        mem_wdata_MP = '0;
        mem_wstrb_MP = '0;
        mem_ready_0  = 1'b0;
        mem_ready_1  = 1'b0;
        unique case (state_q)
            ST_OWN0: begin
                mem_valid_MP = mem_valid_0;
                mem_instr_MP = mem_instr_0;
                mem_addr_MP  = mem_addr_0;
                mem_wdata_MP = mem_wdata_0;
                mem_wstrb_MP = mem_wstrb_0;
                mem_ready_0  = mem_ready_MP;
            end
            ST_OWN1: begin
                mem_valid_MP = mem_valid_1;
                mem_instr_MP = mem_instr_1;
                mem_addr_MP  = mem_addr_1;
                mem_wdata_MP = mem_wdata_1;
                mem_wstrb_MP = mem_wstrb_1;
                mem_ready_1  = mem_ready_MP;
            end
            default: ;
        endcase
    end

    assign mem_rdata_0 = mem_rdata_MP;
    assign mem_rdata_1 = mem_rdata_MP;

`ifdef MP_ARB_STATS_EN
    logic grant_0, grant_1, wait_0, wait_1;

    assign grant_0 = (state_q == ST_IDLE) && (state_d == ST_OWN0);
    assign grant_1 = (state_q == ST_IDLE) && (state_d == ST_OWN1);
    assign wait_0  = mem_valid_0 && !mem_ready_0 && (state_q != ST_OWN0);
    assign wait_1  = mem_valid_1 && !mem_ready_1 && (state_q != ST_OWN1);

    mp_arb_stats u_stats (
        .clk         (clk),
        .resetn      (resetn),
        .grant_0     (grant_0),
        .grant_1     (grant_1),
        .wait_0      (wait_0),
        .wait_1      (wait_1),
        .grant_cnt_0 (grant_cnt_0),
        .grant_cnt_1 (grant_cnt_1),
        .wait_cnt_0  (wait_cnt_0),
        .wait_cnt_1  (wait_cnt_1)
    );
`endif

endmodule
